// File: rtl/ika9958_regbank.sv
// ika9958_regbank: VDP control register bank with the CPU-side write
// protocol. Handles the two-byte control-port sequence on port #1, the
// auto-incrementing indirect port #3 through the pointer register, and
// forced-zero bits on the lock register. Consumers read the flat bus.
module ika9958_regbank #(
    parameter int         REG_COUNT = 64,
    parameter int         ADDR_W    = 6,
    parameter int         IND_REG   = 17,
    parameter int         LOCK_REG  = 9,
    parameter logic [7:0] LOCK_MASK = 8'h01
) (
    input  logic                   i_EMUCLK,
    input  logic                   i_RST,
    input  logic                   i_CPU_WR,
    input  logic                   i_CPU_RD,
    input  logic [1:0]             i_PORT,
    input  logic [7:0]             i_DIN,
    output logic [REG_COUNT*8-1:0] o_REGFILE,
    output logic                   o_WR_STB,
    output logic [ADDR_W-1:0]      o_WR_ADDR,
    output logic                   o_LATCH_PEND
);

    typedef enum logic {
        IDLE  = 1'b0,
        FIRST = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] IND_ADDR  = ADDR_W'(IND_REG);
    localparam logic [ADDR_W-1:0] LOCK_ADDR = ADDR_W'(LOCK_REG);
    localparam logic [ADDR_W:0]   COUNT_LIM = (ADDR_W+1)'(REG_COUNT);

    state_t                 state;
    logic [7:0]             data_latch;
    logic [REG_COUNT*8-1:0] regfile;

    logic                   ctrl_wr;
    logic                   ind_wr;
    logic                   rd_abort;
    logic [7:0]             pointer;
    logic [7:0]             pointer_next;
    logic                   ptr_inc;
    logic                   cand_valid;
    logic [ADDR_W-1:0]      cand_addr;
    logic [7:0]             cand_data;
    logic                   wr_en;
    logic [7:0]             wr_data;

    // Decode the CPU access into at most one register write plus an optional pointer bump
    always_comb begin
        ctrl_wr      = i_CPU_WR && (i_PORT == 2'd1);
        ind_wr       = i_CPU_WR && (i_PORT == 2'd3);
        rd_abort     = i_CPU_RD && !i_CPU_WR && (i_PORT == 2'd1) && (state == FIRST);
        pointer      = regfile[IND_REG*8 +: 8];
        pointer_next = pointer;
        pointer_next[ADDR_W-1:0] = pointer[ADDR_W-1:0] + ADDR_W'(1);
        ptr_inc      = ind_wr && !pointer[7];
        cand_valid   = 1'b0;
        cand_addr    = '0;
        cand_data    = '0;
        if (ctrl_wr && (state == FIRST) && i_DIN[7]) begin
            cand_valid = 1'b1;
            cand_addr  = i_DIN[ADDR_W-1:0];
            cand_data  = data_latch;
        end else if (ind_wr) begin
            cand_addr  = pointer[ADDR_W-1:0];
            cand_data  = i_DIN;
            cand_valid = (cand_addr != IND_ADDR);
        end
        wr_en   = cand_valid && ({1'b0, cand_addr} < COUNT_LIM);
        wr_data = (cand_addr == LOCK_ADDR) ? (cand_data & ~LOCK_MASK) : cand_data;
    end

    // Register file, write strobe and the two-state control-port sequencer
    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            regfile      <= '0;
            data_latch   <= '0;
            state        <= IDLE;
            o_WR_STB     <= 1'b0;
            o_WR_ADDR    <= '0;
            o_LATCH_PEND <= 1'b0;
        end else begin
            if (wr_en) begin
                regfile[cand_addr*8 +: 8] <= wr_data;
            end
            if (ptr_inc) begin
                regfile[IND_REG*8 +: 8] <= pointer_next;
            end
            o_WR_STB <= wr_en;
            if (wr_en) begin
                o_WR_ADDR <= cand_addr;
            end
            case (state)
                IDLE: begin
                    if (ctrl_wr) begin
                        data_latch   <= i_DIN;
                        state        <= FIRST;
                        o_LATCH_PEND <= 1'b1;
                    end
                end
                FIRST: begin
                    if (ctrl_wr || rd_abort) begin
                        state        <= IDLE;
                        o_LATCH_PEND <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    o_LATCH_PEND <= 1'b0;
                end
            endcase
        end
    end

    assign o_REGFILE = regfile;

endmodule

// File: tb/tb_ika9958_regbank.sv
// tb_ika9958_regbank: directed test-plan steps followed by random CPU
// traffic, each cycle compared against a behavioural register-bank model.
module tb_ika9958_regbank;

    logic         i_EMUCLK = 1'b0;
    logic         i_RST    = 1'b0;
    logic         i_CPU_WR = 1'b0;
    logic         i_CPU_RD = 1'b0;
    logic [1:0]   i_PORT   = 2'd0;
    logic [7:0]   i_DIN    = 8'h00;
    logic [511:0] o_REGFILE;
    logic         o_WR_STB;
    logic [5:0]   o_WR_ADDR;
    logic         o_LATCH_PEND;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    byte unsigned mregs [64];
    byte unsigned mlatch  = 0;
    bit           mpend   = 0;
    bit           exp_stb = 0;
    int           exp_adr = 0;

    ika9958_regbank dut (
        .i_EMUCLK     (i_EMUCLK),
        .i_RST        (i_RST),
        .i_CPU_WR     (i_CPU_WR),
        .i_CPU_RD     (i_CPU_RD),
        .i_PORT       (i_PORT),
        .i_DIN        (i_DIN),
        .o_REGFILE    (o_REGFILE),
        .o_WR_STB     (o_WR_STB),
        .o_WR_ADDR    (o_WR_ADDR),
        .o_LATCH_PEND (o_LATCH_PEND)
    );

    // Free-running clock
    always #5 i_EMUCLK = ~i_EMUCLK;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_write(input int a, input byte unsigned d);
        if (a < 64) begin
            mregs[a] = (a == 9) ? (d & 8'hFE) : d;
            exp_stb  = 1;
            exp_adr  = a;
        end
    endfunction

    function automatic void model_step(input bit wr, input bit rd, input bit rst,
                                       input int port, input byte unsigned din);
        int p;
        exp_stb = 0;
        if (rst) begin
            foreach (mregs[n]) mregs[n] = 0;
            mpend   = 0;
            mlatch  = 0;
            exp_adr = 0;
            return;
        end
        if (wr && port == 1) begin
            if (!mpend) begin
                mlatch = din;
                mpend  = 1;
            end else begin
                mpend = 0;
                if (din >= 128) model_write(din % 64, mlatch);
            end
        end else if (wr && port == 3) begin
            p = mregs[17];
            if ((p % 64) != 17) model_write(p % 64, din);
            if (p < 128) mregs[17] = byte'((p / 64) * 64 + ((p + 1) % 64));
        end else if (!wr && rd && port == 1 && mpend) begin
            mpend = 0;
        end
    endfunction

    task automatic checkOutput();
        logic [511:0] flat;
        for (int n = 0; n < 64; n++) flat[n*8 +: 8] = mregs[n];
        chk("regfile", o_REGFILE, flat);
        chk("wr_stb", 512'(o_WR_STB), 512'(exp_stb));
        chk("wr_addr", 512'(o_WR_ADDR), 512'(exp_adr));
        chk("latch_pend", 512'(o_LATCH_PEND), 512'(mpend));
    endtask

    // One bus cycle: drive at a falling edge, sample at the next falling edge
    task automatic applyStimulus(input bit wr, input bit rd, input bit rst,
                                 input int port, input byte unsigned din);
        i_CPU_WR = wr;
        i_CPU_RD = rd;
        i_RST    = rst;
        i_PORT   = 2'(port);
        i_DIN    = din;
        @(negedge i_EMUCLK);
        i_CPU_WR = 1'b0;
        i_CPU_RD = 1'b0;
        i_RST    = 1'b0;
        model_step(wr, rd, rst, port, din);
        checkOutput();
    endtask

    task automatic ctrlWrite(input byte unsigned a, input byte unsigned b);
        applyStimulus(1, 0, 0, 1, a);
        applyStimulus(1, 0, 0, 1, b);
    endtask

    // Directed test-plan steps followed by randomized traffic
    initial begin
        int r;
        foreach (mregs[n]) mregs[n] = 0;
        @(negedge i_EMUCLK);
        applyStimulus(0, 0, 1, 0, 8'h00);
        applyStimulus(0, 0, 1, 0, 8'h00);
        chk("reset_pend", 512'(o_LATCH_PEND), 512'(0));

        applyStimulus(1, 0, 0, 1, 8'h5A);
        chk("pend_after_first", 512'(o_LATCH_PEND), 512'(1));
        applyStimulus(1, 0, 0, 1, 8'h87);
        chk("reg7", 512'(o_REGFILE[7*8 +: 8]), 512'(8'h5A));
        chk("stb_reg7", 512'({o_WR_STB, o_WR_ADDR}), 512'({1'b1, 6'd7}));
        applyStimulus(0, 0, 0, 0, 8'h00);

        ctrlWrite(8'hFF, 8'h89);
        chk("reg9_locked", 512'(o_REGFILE[9*8 +: 8]), 512'(8'hFE));
        ctrlWrite(8'h12, 8'h40);
        chk("vram_setup_nostb", 512'(o_WR_STB), 512'(0));

        applyStimulus(1, 0, 0, 1, 8'h33);
        applyStimulus(0, 1, 0, 1, 8'h00);
        chk("rd_abort", 512'(o_LATCH_PEND), 512'(0));
        ctrlWrite(8'h44, 8'h82);
        chk("reg2", 512'(o_REGFILE[2*8 +: 8]), 512'(8'h44));

        ctrlWrite(8'h3E, 8'h91);
        applyStimulus(1, 0, 0, 3, 8'hA1);
        applyStimulus(1, 0, 0, 3, 8'hA2);
        applyStimulus(1, 0, 0, 3, 8'hA3);
        chk("reg62", 512'(o_REGFILE[62*8 +: 8]), 512'(8'hA1));
        chk("reg63", 512'(o_REGFILE[63*8 +: 8]), 512'(8'hA2));
        chk("reg0", 512'(o_REGFILE[0 +: 8]), 512'(8'hA3));
        chk("r17_wrap", 512'(o_REGFILE[17*8 +: 8]), 512'(8'h01));

        ctrlWrite(8'h91, 8'h91);
        applyStimulus(1, 0, 0, 3, 8'h55);
        applyStimulus(1, 0, 0, 3, 8'h66);
        chk("r17_self", 512'(o_REGFILE[17*8 +: 8]), 512'(8'h91));
        chk("r17_self_nostb", 512'(o_WR_STB), 512'(0));
        ctrlWrite(8'h85, 8'h91);
        applyStimulus(1, 0, 0, 3, 8'h11);
        applyStimulus(1, 0, 0, 3, 8'h22);
        chk("reg5", 512'(o_REGFILE[5*8 +: 8]), 512'(8'h22));
        chk("r17_hold", 512'(o_REGFILE[17*8 +: 8]), 512'(8'h85));

        applyStimulus(1, 0, 0, 1, 8'h77);
        applyStimulus(0, 0, 1, 0, 8'h00);
        applyStimulus(1, 0, 0, 1, 8'h83);
        chk("rst_mid_pend", 512'(o_LATCH_PEND), 512'(1));
        chk("rst_mid_nostb", 512'(o_WR_STB), 512'(0));
        applyStimulus(0, 1, 0, 1, 8'h00);

        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 99);
            if (r < 2)
                applyStimulus(0, 0, 1, 0, 8'h00);
            else if (r < 12)
                applyStimulus(0, 1, 0, $urandom_range(0, 3), 8'($urandom));
            else if (r < 20)
                applyStimulus(1, 1, 0, $urandom_range(0, 3), 8'($urandom));
            else if (r < 60)
                applyStimulus(1, 0, 0, 1, 8'($urandom));
            else if (r < 90)
                applyStimulus(1, 0, 0, 3, 8'($urandom));
            else
                applyStimulus($urandom_range(0, 1), 0, 0, $urandom_range(0, 1) * 2, 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ika9958_regbank.md
Name: ika9958_regbank

Overview:
- Parametrised successor to the IKA9958 VDP register file: owns the control register bank and implements the CPU-side write protocol itself.
- Supports a two-byte control-port write (data byte, then register number) and an indirect port with auto-increment through the R#17 pointer.
- Applies per-bank forced-zero bit masks.
- Sits between the CPU bus decoder and all VDP consumers; consumers read the flat register bus.

Parameters:
- REG_COUNT, 64, number of 8-bit registers implemented (1..2^ADDR_W).
- ADDR_W, 6, register address width.
- IND_REG, 17, index of the indirect pointer register.
- LOCK_REG, 9, register that carries forced-zero bits.
- LOCK_MASK, 8'h01, bits of LOCK_REG that always read and store 0.

Ports:
- i_EMUCLK  in  1  system clock; all state updates on the rising edge.
- i_RST  in  1  synchronous active-high reset.
- i_CPU_WR  in  1  one-cycle CPU write strobe.
- i_CPU_RD  in  1  one-cycle CPU read strobe on the status port (port #1).
- i_PORT  in  2  port select: 2'd1 = control port #1, 2'd3 = indirect port #3; other values are ignored.
- i_DIN  in  8  CPU write data.
- o_REGFILE  out  REG_COUNT*8  flat register bus; register n occupies bits [8n+7:8n].
- o_WR_STB  out  1  one-cycle pulse after any register update.
- o_WR_ADDR  out  ADDR_W  address of the last updated register.
- o_LATCH_PEND  out  1  high while the first control byte is held.

Behaviour:
- Interface: one clock, i_EMUCLK; reset i_RST is synchronous and active-high.
- Reset: all registers, o_WR_STB, o_WR_ADDR, o_LATCH_PEND and the FSM clear to 0/IDLE. Reset mid-sequence discards the latched byte.
- Control FSM, two states: IDLE and FIRST.
  - IDLE + WR on port 1: latch i_DIN into the data latch; go to FIRST; o_LATCH_PEND=1.
  - FIRST + WR on port 1, i_DIN[7]=1: write the latch to reg[i_DIN[ADDR_W-1:0]]; go to IDLE.
  - FIRST + WR on port 1, i_DIN[7]=0: VRAM address setup, which this block does not handle; no register write; go to IDLE.
  - FIRST + RD strobe: go to IDLE; the latch is discarded.
  - WR and RD in the same cycle: WR is processed and RD is ignored.
- Indirect port 3 write:
  - Target address is reg[IND_REG][ADDR_W-1:0].
  - Writes to IND_REG itself are discarded.
  - If reg[IND_REG][7]=0, the pointer increments modulo 2^ADDR_W (63 wraps to 0); bit 7 and the bits above ADDR_W are preserved.
  - Increment applies even when the write is discarded.
  - Indirect writes do not change the control FSM state or the latch.
- Address >= REG_COUNT: the write is discarded and no strobe is issued. Pointer increment still applies.
- Lock mask: on a write to LOCK_REG, the stored value is data & ~LOCK_MASK. The masked bits stay 0 from reset onward.
- Latency:
  - The register updates at the edge that samples i_CPU_WR.
  - o_REGFILE shows the new value from the following cycle.
  - o_WR_STB and o_WR_ADDR are registered: high for exactly one cycle, coincident with the new o_REGFILE value.
  - Back-to-back indirect writes on consecutive cycles are fully supported, one register per cycle.
- o_REGFILE is driven from flops only; no combinational path from i_DIN.

Test Plan:
- Reset, then port-1 writes 8'h5A, 8'h87 -> reg7=8'h5A one cycle after the second write; o_WR_STB pulses with o_WR_ADDR=7; o_LATCH_PEND goes 1 then 0.
- Port-1 writes 8'hFF, 8'h89 -> reg9=8'hFE (LOCK_MASK applied). Port-1 writes 8'h12, 8'h40 -> no register changes and no strobe; FSM is back in IDLE.
- Port-1 write 8'h33, then RD strobe, then port-1 writes 8'h44, 8'h82 -> reg2=8'h44; 8'h33 is never written.
- Set R17=8'h3E; three port-3 writes 8'hA1, 8'hA2, 8'hA3 on consecutive cycles -> reg62=A1, reg63=A2, reg0=A3; R17 ends at 8'h01.
- Set R17=8'h91 (no increment), then two port-3 writes -> reg17 unchanged and no strobe. Set R17=8'h85; two port-3 writes 8'h11, 8'h22 -> reg5=8'h22; R17 stays 8'h85.
- Port-1 write 8'h77, then i_RST for one cycle, then port-1 write 8'h83 -> no register write; o_LATCH_PEND=1 (8'h83 is treated as a new first byte).
